// File: rtl/strobe_decoder_pkg.sv
// Shared definitions for the strobe decoder slice.
// Holds the FSM state encoding and the code / one-hot width constants.
package strobe_decoder_pkg;

   localparam int CODE_W   = 4;
   localparam int ONEHOT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/strobe_decoder_onehot_dec4.sv
// Purely combinational 4-to-16 decoder.
// Ports:
//   code   - index to decode (0..15)
//   onehot - exactly one bit set, bit position equal to code
module onehot_dec4
   import strobe_decoder_pkg::*;
(
   input  logic [CODE_W-1:0]   code,
   output logic [ONEHOT_W-1:0] onehot
);

   always_comb begin
      onehot       = '0;
      onehot[code] = 1'b1;
   end

endmodule

// File: rtl/strobe_decoder.sv
// Registered 4-to-16 one-hot strobe generator with a valid/ready handshake.
// An accepted code drives its one-hot line for HOLD_CYCLES clocks, then the
// block stays unready for GAP_CYCLES clocks before taking the next code.
// Ports:
//   i_clk, i_reset_n - clock, synchronous active-low reset
//   i_enable         - low blocks acceptance and aborts an active strobe
//   i_valid, i_code  - code handshake input
//   o_ready          - combinational: idle and enabled
//   o_onehot         - registered strobe (1 << code) or zero
//   o_active         - high while o_onehot is nonzero
//   o_done           - one-cycle pulse after a strobe completes unaborted
//
// state | meaning
// IDLE  | waiting for a code, o_ready follows i_enable
// HOLD  | strobe asserted, counter counts remaining hold cycles
// GAP   | forced idle after a strobe, counter counts remaining gap cycles
module strobe_decoder
   import strobe_decoder_pkg::*;
#(
   parameter int HOLD_CYCLES = 3,
   parameter int GAP_CYCLES  = 1,
   parameter int CNT_W       = 8
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_enable,
   input  logic                i_valid,
   input  logic [CODE_W-1:0]   i_code,
   output logic                o_ready,
   output logic [ONEHOT_W-1:0] o_onehot,
   output logic                o_active,
   output logic                o_done
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   // GAP_LOAD is only used when GAP_CYCLES > 0; guard keeps it from underflowing.
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ONEHOT_W-1:0]   onehot_q, onehot_d;
   logic                  active_q, active_d;
   logic                  done_q, done_d;
   logic [ONEHOT_W-1:0]   dec_onehot;
   logic                  accept;

   onehot_dec4 u_dec (
      .code   (i_code),
      .onehot (dec_onehot)
   );

   assign o_ready = (state_q == IDLE) && i_enable;
   assign accept  = i_valid && o_ready;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         onehot_q <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         onehot_q <= onehot_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (!i_enable) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  cnt_d   = GAP_LOAD;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GAP: begin
            if (!i_enable || (cnt_q == '0)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The code is latched as its decoded one-hot pattern and recirculated
   // through HOLD, so i_code changes cannot disturb an active strobe.
   always_comb begin
      onehot_d = '0;
      if (accept) begin
         onehot_d = dec_onehot;
      end else if ((state_q == HOLD) && (state_d == HOLD)) begin
         onehot_d = onehot_q;
      end
      active_d = (state_d == HOLD);
      done_d   = (state_q == HOLD) && i_enable && (cnt_q == '0);
   end

   assign o_onehot = onehot_q;
   assign o_active = active_q;
   assign o_done   = done_q;

endmodule
